// File: rtl/modn_arb_pkg.sv
// Shared types and constants for the mod-N counter arbiter.
package modn_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } arb_state_e;

    localparam logic OP_STEP = 1'b0;
    localparam logic OP_LOAD = 1'b1;

endpackage

// File: rtl/modn_updown_counter.sv
// Loadable mod-MOD up/down counter; load has priority over enable.
module modn_updown_counter
    import modn_arb_pkg::*;
#(
    parameter int MOD = 12,
    localparam int CW = $clog2(MOD)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          enable,
    input  logic          up,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] MAX_VAL = CW'(MOD - 1);

    // Count register: load (reduced mod MOD) or step with wrap in either direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(32'(load_val) % 32'(MOD));
        end else if (enable) begin
            if (up) begin
                count <= (count == MAX_VAL) ? '0 : count + 1'b1;
            end else begin
                count <= (count == '0) ? MAX_VAL : count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/modn_counter_arbiter.sv
// Round-robin arbiter that runs one requester's LOAD/STEP command at a time
// on a shared mod-MOD up/down counter.
module modn_counter_arbiter
    import modn_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MOD     = 12,
    localparam int CW     = $clog2(MOD)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    op,
    input  logic [NUM_REQ-1:0]    dir,
    input  logic [NUM_REQ*CW-1:0] arg,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic                  busy,
    output logic [CW-1:0]         count
);

    localparam int          IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NR   = NUM_REQ;
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

    arb_state_e    state, next_state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] win_idx;
    logic          cmd_op;
    logic          cmd_dir;
    logic [CW-1:0] cmd_arg;
    logic [CW-1:0] rem;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    int unsigned   cand;

    logic          ctr_load;
    logic          ctr_en;

    // Round-robin pick: first set request at or after rr_ptr, wrapping upward.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned i = 0; i < NR; i++) begin
            cand = (32'(rr_ptr) + i) % NR;
            if (!pick_valid && req[IW'(cand)]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'(cand);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and counter control; STEP with rem==0 issues no enable.
    always_comb begin
        next_state = state;
        ctr_load   = 1'b0;
        ctr_en     = 1'b0;
        done       = '0;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (cmd_op == OP_LOAD) begin
                    ctr_load   = 1'b1;
                    next_state = DONE;
                end else begin
                    ctr_en = (rem != '0);
                    if (rem <= CW'(1)) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                done       = gnt;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Command latch, remaining-step counter, grant and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            win_idx <= '0;
            cmd_op  <= OP_STEP;
            cmd_dir <= 1'b0;
            cmd_arg <= '0;
            rem     <= '0;
            gnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        win_idx <= pick_idx;
                        cmd_op  <= op[pick_idx];
                        cmd_dir <= dir[pick_idx];
                        cmd_arg <= arg[pick_idx*CW +: CW];
                        rem     <= arg[pick_idx*CW +: CW];
                        gnt     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    end
                end
                RUN: begin
                    if (cmd_op == OP_STEP && rem > CW'(1)) begin
                        rem <= rem - 1'b1;
                    end
                end
                DONE: begin
                    gnt    <= '0;
                    rr_ptr <= (win_idx == LAST) ? '0 : win_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

    modn_updown_counter #(
        .MOD(MOD)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ctr_load),
        .load_val (cmd_arg),
        .enable   (ctr_en),
        .up       (cmd_dir),
        .count    (count)
    );

endmodule

// File: tb/tb_modn_counter_arbiter.sv
// Directed self-checking bench for modn_counter_arbiter (NUM_REQ=4, MOD=12).
module tb_modn_counter_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  op;
    logic [3:0]  dir;
    logic [15:0] arg;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    modn_counter_arbiter #(
        .NUM_REQ(4),
        .MOD    (12)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .op    (op),
        .dir   (dir),
        .arg   (arg),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int i, input logic o, input logic d, input logic [3:0] a);
        op[i]         = o;
        dir[i]        = d;
        arg[i*4 +: 4] = a;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        op    = '0;
        dir   = '0;
        arg   = '0;
        #12;
        check("reset_count", 32'(count), 0);
        check("reset_gnt",   32'(gnt),   0);
        check("reset_done",  32'(done),  0);
        check("reset_busy",  32'(busy),  0);
        rst_n = 1'b1;
        tick();

        // LOAD 13 by req0 -> 13 % 12 = 1
        set_cmd(0, 1'b1, 1'b0, 4'd13);
        req = 4'b0001;
        tick();
        req = '0;
        check("load_gnt",  32'(gnt),  32'b0001);
        check("load_busy", 32'(busy), 1);
        check("load_done_early", 32'(done), 0);
        tick();
        check("load_count", 32'(count), 1);
        check("load_done",  32'(done),  32'b0001);
        tick();
        check("load_idle_busy", 32'(busy), 0);
        check("load_idle_gnt",  32'(gnt),  0);
        check("load_idle_done", 32'(done), 0);

        // LOAD 10 by req1 (rr_ptr now 1)
        set_cmd(1, 1'b1, 1'b0, 4'd10);
        req = 4'b0010;
        tick();
        req = '0;
        check("load10_gnt", 32'(gnt), 32'b0010);
        tick();
        check("load10_count", 32'(count), 10);
        tick();

        // STEP up 3 by req1 across wrap (rr_ptr now 2, search wraps to 1)
        set_cmd(1, 1'b0, 1'b1, 4'd3);
        req = 4'b0010;
        tick();
        req = '0;
        check("up_gnt",    32'(gnt),   32'b0010);
        check("up_count0", 32'(count), 10);
        tick();
        check("up_count1", 32'(count), 11);
        check("up_done1",  32'(done),  0);
        tick();
        check("up_count2", 32'(count), 0);
        check("up_done2",  32'(done),  0);
        tick();
        check("up_count3", 32'(count), 1);
        check("up_done3",  32'(done),  32'b0010);
        tick();
        check("up_idle_count", 32'(count), 1);

        // LOAD 0 by req2, then STEP down 2 by req2 across wrap
        set_cmd(2, 1'b1, 1'b0, 4'd0);
        req = 4'b0100;
        tick();
        req = '0;
        tick();
        check("load0_count", 32'(count), 0);
        tick();
        set_cmd(2, 1'b0, 1'b0, 4'd2);
        req = 4'b0100;
        tick();
        req = '0;
        check("down_gnt", 32'(gnt), 32'b0100);
        tick();
        check("down_count1", 32'(count), 11);
        check("down_done1",  32'(done),  0);
        tick();
        check("down_count2", 32'(count), 10);
        check("down_done2",  32'(done),  32'b0100);
        tick();

        // LOAD 5 by req3 (rr_ptr 3 -> 0 afterwards)
        set_cmd(3, 1'b1, 1'b0, 4'd5);
        req = 4'b1000;
        tick();
        req = '0;
        tick();
        check("load5_count", 32'(count), 5);
        tick();

        // Fairness: all requesters STEP 0, req held at 1111
        for (int i = 0; i < 4; i++) set_cmd(i, 1'b0, 1'b1, 4'd0);
        req = 4'b1111;
        tick();
        check("fair_gnt0",  32'(gnt),  32'b0001);
        tick();
        check("fair_done0", 32'(done), 32'b0001);
        tick();
        check("fair_idle0", 32'(gnt),  0);
        tick();
        check("fair_gnt1",  32'(gnt),  32'b0010);
        tick();
        check("fair_done1", 32'(done), 32'b0010);
        tick();
        tick();
        check("fair_gnt2",  32'(gnt),  32'b0100);
        tick();
        check("fair_done2", 32'(done), 32'b0100);
        tick();
        tick();
        check("fair_gnt3",  32'(gnt),  32'b1000);
        tick();
        check("fair_done3", 32'(done), 32'b1000);
        tick();
        tick();
        req = '0;
        check("fair_gnt4",  32'(gnt),  32'b0001);
        check("fair_count", 32'(count), 5);
        tick();
        tick();

        // Zero step by req3 at count 5; arg3 changed while busy is ignored
        set_cmd(3, 1'b0, 1'b1, 4'd0);
        req = 4'b1000;
        tick();
        req = '0;
        arg[12 +: 4] = 4'd7;
        check("zero_gnt", 32'(gnt), 32'b1000);
        tick();
        check("zero_done",  32'(done),  32'b1000);
        check("zero_count", 32'(count), 5);
        tick();
        check("zero_idle_count", 32'(count), 5);
        check("zero_idle_busy",  32'(busy),  0);

        // Reset in the middle of a STEP run
        set_cmd(0, 1'b0, 1'b1, 4'd5);
        req = 4'b0001;
        tick();
        req = '0;
        check("rst_pre_gnt", 32'(gnt), 32'b0001);
        tick();
        check("rst_pre_count", 32'(count), 6);
        rst_n = 1'b0;
        #1;
        check("rst_mid_count", 32'(count), 0);
        check("rst_mid_gnt",   32'(gnt),   0);
        check("rst_mid_done",  32'(done),  0);
        check("rst_mid_busy",  32'(busy),  0);
        #2;
        rst_n = 1'b1;
        tick();
        check("rst_post_busy",  32'(busy),  0);
        check("rst_post_done",  32'(done),  0);
        check("rst_post_count", 32'(count), 0);
        tick();
        check("rst_post2_done", 32'(done), 0);
        check("rst_post2_gnt",  32'(gnt),  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
